uart_rx_deser: RTL and testbench

// - Receive side of the UART link: deserialises the asynchronous rx line into parallel bytes.
// - Checks start, parity and stop bits and presents each good byte on a valid/ready output.
// - Sits between the board rx pin and the command/readback logic. Its line format matches the transmitter:

---
 rtl/uart_rx_deser.sv | 208 ++++++++++++++++++++
 tb/tb_uart_rx_deser.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deser.sv
// uart_rx_deser: UART receive deserialiser.
// Line format: start(0), DATA_W data bits LSB first, optional odd parity bit, stop(1).
// Optional build macro UART_RX_MAJORITY_EN: each bit decision is the 2-of-3 majority
// of the synchronised line around mid-bit, taken one cycle later than the single sample.
// Output handshake: rd_data is held stable while rd_vld=1; a byte transfers on any
// cycle with rd_vld & rd_rdy; rd_rdy is ignored while rd_vld=0.
module uart_rx_deser #(
  parameter int CLK_FREQ = 50000000,
  parameter int BR       = 115200,
  parameter int DATA_W   = 8,
  parameter int CHECK    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_vld,
  input  logic              rd_rdy,
  output logic              par_err,
  output logic              frm_err,
  output logic              ovf
);

  localparam int BR_DIV = CLK_FREQ / BR;
  localparam int CNT_W  = $clog2(BR_DIV);
  localparam int BIT_W  = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BR_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BR_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_vld_q, rd_vld_d;
  logic                par_err_q, par_err_d;
  logic                frm_err_q, frm_err_d;
  logic                ovf_q, ovf_d;

  logic rx_m_q, rx_s_q, rx_d_q;
  logic fall;
  logic strobe;
  logic samp;

  // Two-flop synchroniser plus a delay flop for falling-edge detection; idle line is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
      rx_d_q <= 1'b1;
    end else begin
      rx_m_q <= rx;
      rx_s_q <= rx_m_q;
      rx_d_q <= rx_s_q;
    end
  end

  assign fall = rx_d_q & ~rx_s_q;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(BR_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_DEC = CNT_W'(BR_DIV / 2 + 1);

  logic maj_a_q, maj_a_d;
  logic maj_b_q, maj_b_d;

  // Capture the two early votes; the third is the live line at the decision count.
  always_comb begin
    maj_a_d = maj_a_q;
    maj_b_d = maj_b_q;
    if (cnt_q == CNT_PRE) maj_a_d = rx_s_q;
    if (cnt_q == CNT_MID) maj_b_d = rx_s_q;
  end

  // Majority vote registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      maj_a_q <= 1'b1;
      maj_b_q <= 1'b1;
    end else begin
      maj_a_q <= maj_a_d;
      maj_b_q <= maj_b_d;
    end
  end

  assign strobe = (cnt_q == CNT_DEC);
  assign samp   = (maj_a_q & maj_b_q) | (maj_a_q & rx_s_q) | (maj_b_q & rx_s_q);
`else
  assign strobe = (cnt_q == CNT_MID);
  assign samp   = rx_s_q;
`endif

  // Next-state, counters, shift register and output handshake.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    err_d     = err_q;
    rd_data_d = rd_data_q;
    rd_vld_d  = rd_vld_q & ~rd_rdy;
    par_err_d = 1'b0;
    frm_err_d = 1'b0;
    ovf_d     = 1'b0;

    // Baud counter free-runs with wrap while a frame is in progress.
    if (state_q != IDLE) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = START;
          err_d   = 1'b0;
          bit_d   = '0;
        end
      end
      START: begin
        if (strobe) begin
          // A high line at mid start bit is a glitch: drop it silently.
          state_d = samp ? IDLE : DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (strobe) begin
          shift_d = {samp, shift_q[DATA_W-1:1]};
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = (CHECK != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (strobe) begin
          if (samp != ~^shift_q) err_d = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (strobe) begin
          state_d = IDLE;
          if (!samp) begin
            frm_err_d = 1'b1;
          end else if (err_q) begin
            par_err_d = 1'b1;
          end else if (!rd_vld_q || rd_rdy) begin
            rd_data_d = shift_q;
            rd_vld_d  = 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      ovf_q     <= ovf_d;
    end
  end

  assign rd_data = rd_data_q;
  assign rd_vld  = rd_vld_q;
  assign par_err = par_err_q;
  assign frm_err = frm_err_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// tb_uart_rx_deser: directed bench for uart_rx_deser at default parameters.
module tb_uart_rx_deser;

  localparam int BIT = 50000000 / 115200;   // 434 clocks per bit
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = 4562;                // start edge drive -> rd_vld visible
`else
  localparam int LAT = 4561;
`endif

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] rd_data;
  logic       rd_vld;
  logic       rd_rdy;
  logic       par_err;
  logic       frm_err;
  logic       ovf;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int n_par = 0, n_frm = 0, n_ovf = 0, n_rise = 0, rise_cyc = 0;
  logic vld_prev = 1'b0;
  int b_par, b_frm, b_ovf, b_rise;

  uart_rx_deser dut (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .rd_data (rd_data),
    .rd_vld  (rd_vld),
    .rd_rdy  (rd_rdy),
    .par_err (par_err),
    .frm_err (frm_err),
    .ovf     (ovf)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: counts high cycles of each pulse and rd_vld rising edges.
  always @(posedge clk) begin
    #1;
    if (par_err === 1'b1) n_par = n_par + 1;
    if (frm_err === 1'b1) n_frm = n_frm + 1;
    if (ovf === 1'b1)     n_ovf = n_ovf + 1;
    if (rd_vld === 1'b1 && vld_prev !== 1'b1) begin
      n_rise   = n_rise + 1;
      rise_cyc = cyc;
    end
    vld_prev = rd_vld;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_par  = n_par;
    b_frm  = n_frm;
    b_ovf  = n_ovf;
    b_rise = n_rise;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame; g is the frame bit index (0=start) that gets a 1-clk mid-bit glitch, 99 for none.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int g);
    logic [10:0] fb;
    fb = {s, p, d, 1'b0};
    start_cyc = cyc;
    for (int i = 0; i < 11; i++) begin
      rx = fb[i];
      if (i == g) begin
        repeat (218) @(negedge clk);
        rx = ~fb[i];
        @(negedge clk);
        rx = fb[i];
        repeat (BIT - 219) @(negedge clk);
      end else begin
        repeat (BIT) @(negedge clk);
      end
    end
    rx = 1'b1;
  endtask

  task automatic consume();
    rd_rdy = 1'b1;
    @(negedge clk);
    rd_rdy = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    rx     = 1'b1;
    rd_rdy = 1'b0;
    idle(4);
    chk("rst_rd_data", {24'b0, rd_data}, 32'h0);
    chk("rst_rd_vld", {31'b0, rd_vld}, 32'h0);
    chk("rst_par_err", {31'b0, par_err}, 32'h0);
    chk("rst_frm_err", {31'b0, frm_err}, 32'h0);
    chk("rst_ovf", {31'b0, ovf}, 32'h0);
    rst = 1'b0;
    idle(20);

    // Good frame 0xA5, odd parity bit 1.
    snap();
    send_frame(8'hA5, 1'b1, 1'b1, 99);
    chk("a5_vld", {31'b0, rd_vld}, 32'h1);
    chk("a5_data", {24'b0, rd_data}, 32'hA5);
    chk("a5_latency", rise_cyc - start_cyc, LAT);
    chk("a5_par_pulses", n_par - b_par, 0);
    chk("a5_frm_pulses", n_frm - b_frm, 0);
    chk("a5_ovf_pulses", n_ovf - b_ovf, 0);
    consume();
    chk("a5_consumed", {31'b0, rd_vld}, 32'h0);
    idle(10);

    // 0x3C has four ones so the correct odd parity bit is 1; send it inverted.
    snap();
    send_frame(8'h3C, 1'b0, 1'b1, 99);
    idle(5);
    chk("3c_par_pulses", n_par - b_par, 1);
    chk("3c_frm_pulses", n_frm - b_frm, 0);
    chk("3c_no_rise", n_rise - b_rise, 0);
    chk("3c_vld", {31'b0, rd_vld}, 32'h0);
    idle(10);

    // 0x55 with stop bit 0: framing error wins, frame dropped.
    snap();
    send_frame(8'h55, 1'b1, 1'b0, 99);
    idle(10);
    chk("55_frm_pulses", n_frm - b_frm, 1);
    chk("55_par_pulses", n_par - b_par, 0);
    chk("55_no_rise", n_rise - b_rise, 0);
    send_frame(8'h0F, 1'b1, 1'b1, 99);
    chk("0f_vld", {31'b0, rd_vld}, 32'h1);
    chk("0f_data", {24'b0, rd_data}, 32'h0F);
    consume();
    idle(10);

    // Short low pulse on the line: rejected at mid start bit.
    snap();
    rx = 1'b0;
    idle(100);
    rx = 1'b1;
    idle(900);
    chk("glitch_no_rise", n_rise - b_rise, 0);
    chk("glitch_pulses", (n_par - b_par) + (n_frm - b_frm) + (n_ovf - b_ovf), 0);
    send_frame(8'h81, 1'b1, 1'b1, 99);
    chk("81_data", {24'b0, rd_data}, 32'h81);
    chk("81_vld", {31'b0, rd_vld}, 32'h1);
    consume();
    idle(10);

    // Overflow: second frame arrives while the first is unconsumed.
    snap();
    send_frame(8'h11, 1'b1, 1'b1, 99);
    chk("11_data", {24'b0, rd_data}, 32'h11);
    send_frame(8'h22, 1'b1, 1'b1, 99);
    chk("22_ovf_pulses", n_ovf - b_ovf, 1);
    chk("22_data_kept", {24'b0, rd_data}, 32'h11);
    chk("22_vld", {31'b0, rd_vld}, 32'h1);
    consume();
    chk("11_consumed", {31'b0, rd_vld}, 32'h0);
    idle(10);

    // Leave 0x5A pending, then reset in the middle of data bit 4 of the next frame.
    send_frame(8'h5A, 1'b1, 1'b1, 99);
    chk("5a_pending", {24'b0, rd_data}, 32'h5A);
    rx = 1'b0;
    idle(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      idle(BIT);
    end
    rx = 1'b1;
    idle(BIT / 2);
    rst = 1'b1;
    #1;
    chk("midrst_vld", {31'b0, rd_vld}, 32'h0);
    chk("midrst_data", {24'b0, rd_data}, 32'h0);
    chk("midrst_pulses", {29'b0, par_err, frm_err, ovf}, 32'h0);
    idle(5);
    rst = 1'b0;
    idle(20);
    snap();
    send_frame(8'hF0, 1'b1, 1'b1, 99);
    chk("f0_data", {24'b0, rd_data}, 32'hF0);
    chk("f0_one_rise", n_rise - b_rise, 1);
    consume();
    idle(10);

`ifdef UART_RX_MAJORITY_EN
    // One-clock glitch at mid data bit 2 (a 0) must not flip the sample.
    send_frame(8'hF0, 1'b1, 1'b1, 3);
    chk("maj_data", {24'b0, rd_data}, 32'hF0);
    consume();
    idle(10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
